// File: rtl/bin_erosion_linebuf_ctrl_if.sv
// ---------------------------------------------------------------------------
// bin_erosion_linebuf_ctrl_if
//   Bundles every non-clock/reset signal of bin_erosion_linebuf_ctrl: the
//   incoming binary pixel stream, both line-buffer FIFO ports, the eroded
//   output stream, status outputs and a debug view of the controller state.
//
//   Pixel handshake: a pixel transfers on a rising clk edge where pix_vld_i
//   and pix_rdy_o are both 1. pix_vld_i may be raised or dropped at any
//   time. pix_rdy_o depends only on controller state and never on
//   pix_vld_i. When pix_rdy_o is 0, pix_i is ignored.
//
//   Modports
//     slave  : the controller side (bin_erosion_linebuf_ctrl)
//     master : the environment side (pixel source, FIFOs, output sink)
//
//   Parameter
//     CNT_W  column/row counter width; stat_cnt_o is 2*CNT_W bits
// ---------------------------------------------------------------------------
interface bin_erosion_linebuf_ctrl_if #(
    parameter int CNT_W = 11
);
    // pixel input stream
    logic               sof_i;
    logic               pix_vld_i;
    logic               pix_i;
    logic               pix_rdy_o;
    // line buffer 0 (holds row y-1)
    logic               lb0_wr_en;
    logic               lb0_wr_data;
    logic               lb0_rd_en;
    logic               lb0_rd_data;
    logic               lb0_full;
    logic               lb0_empty;
    // line buffer 1 (holds row y-2)
    logic               lb1_wr_en;
    logic               lb1_wr_data;
    logic               lb1_rd_en;
    logic               lb1_rd_data;
    logic               lb1_full;
    logic               lb1_empty;
    // eroded output stream and status
    logic               ero_vld_o;
    logic               ero_pix_o;
    logic               ero_eol_o;
    logic               ero_eof_o;
    logic               frm_done_o;
    logic               err_o;
    logic [2*CNT_W-1:0] stat_cnt_o;
    logic [2:0]         state_dbg_o;

    modport slave (
        input  sof_i, pix_vld_i, pix_i,
        input  lb0_rd_data, lb0_full, lb0_empty,
        input  lb1_rd_data, lb1_full, lb1_empty,
        output pix_rdy_o,
        output lb0_wr_en, lb0_wr_data, lb0_rd_en,
        output lb1_wr_en, lb1_wr_data, lb1_rd_en,
        output ero_vld_o, ero_pix_o, ero_eol_o, ero_eof_o,
        output frm_done_o, err_o, stat_cnt_o, state_dbg_o
    );

    modport master (
        output sof_i, pix_vld_i, pix_i,
        output lb0_rd_data, lb0_full, lb0_empty,
        output lb1_rd_data, lb1_full, lb1_empty,
        input  pix_rdy_o,
        input  lb0_wr_en, lb0_wr_data, lb0_rd_en,
        input  lb1_wr_en, lb1_wr_data, lb1_rd_en,
        input  ero_vld_o, ero_pix_o, ero_eol_o, ero_eof_o,
        input  frm_done_o, err_o, stat_cnt_o, state_dbg_o
    );
endinterface

// File: rtl/bin_erosion_linebuf_ctrl.sv
// ---------------------------------------------------------------------------
// bin_erosion_linebuf_ctrl
//   Controls two external 1-bit sync line-buffer FIFOs (read latency 1) to
//   build a 3x3 window over a raster binary pixel stream and emits the
//   eroded pixel (AND of all nine taps) for every interior position.
//
//   Ports
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   bin_erosion_linebuf_ctrl_if.slave:
//             sof_i/pix_vld_i/pix_i/pix_rdy_o      pixel input stream
//             lb0_* / lb1_*                        FIFO controls and status
//             ero_vld_o/ero_pix_o/ero_eol_o/ero_eof_o  eroded output
//             frm_done_o  1-cycle pulse when the last input pixel is taken
//             err_o       sticky FIFO misuse flag (write-full/read-empty)
//             stat_cnt_o  foreground count of the last complete frame
//             state_dbg_o current controller state
//
//   Parameters
//     IMG_W  active pixels per row (3..1024)
//     IMG_H  active rows per frame (3..2047)
//     CNT_W  column/row counter width
//
//   Build option
//     ERO_STAT_EN  when defined, counts foreground output pixels per frame
//                  and publishes the count on stat_cnt_o at frame end;
//                  otherwise stat_cnt_o is constant 0.
//
//   Pipeline
//     accept (cycle c) -> aligned stage d_* (c+1, FIFO read data valid)
//                      -> registered output (c+2)
// ---------------------------------------------------------------------------
module bin_erosion_linebuf_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    bin_erosion_linebuf_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ROW0  = 3'd2,
        S_ROW1  = 3'd3,
        S_ROWN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_t             state;
    logic [CNT_W-1:0]   in_x;
    logic [CNT_W-1:0]   in_y;
    logic               frm_done_q;

    // aligned stage: accepted pixel delayed one clock so it lines up with
    // the FIFO read data requested in the accept cycle
    logic               d_vld;
    logic               d_pix;
    logic               d_lb0;
    logic [CNT_W-1:0]   d_x;
    logic [CNT_W-1:0]   d_y;

    // window columns x-1 (t1) and x-2 (t2); bit 2 = row y-2, bit 0 = row y
    logic [2:0]         t1;
    logic [2:0]         t2;

    logic               ero_vld_q;
    logic               ero_pix_q;
    logic               ero_eol_q;
    logic               ero_eof_q;
    logic               err_q;

    logic               in_row;
    logic               acc;
    logic               col_last;
    logic               go_row0;
    logic [2:0]         col_cur;
    logic               win_and;
    logic               win_out;
    logic               fifo_err;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    assign in_row   = (state == S_ROW0) || (state == S_ROW1) || (state == S_ROWN);
    assign acc      = bus.pix_vld_i & in_row;
    assign col_last = (in_x == X_LAST);

    assign bus.pix_rdy_o   = in_row;
    assign bus.state_dbg_o = state;

    // every accepted pixel enters lb0; lb0 is read back from the second row
    assign bus.lb0_wr_en   = acc;
    assign bus.lb0_wr_data = bus.pix_i;
    assign bus.lb0_rd_en   = (acc & ((state == S_ROW1) || (state == S_ROWN)))
                           | ((state == S_FLUSH) & ~bus.lb0_empty);

    // lb1 is fed with lb0 read data once it has arrived (aligned stage)
    assign bus.lb1_wr_en   = d_vld & d_lb0;
    assign bus.lb1_wr_data = bus.lb0_rd_data;
    assign bus.lb1_rd_en   = (acc & (state == S_ROWN))
                           | ((state == S_FLUSH) & ~bus.lb1_empty);

    // A restart may skip FLUSH only if both FIFOs are empty and nothing is
    // being written into them this very cycle.
    assign go_row0 = bus.lb0_empty & bus.lb1_empty
                   & ~bus.lb0_wr_en & ~bus.lb1_wr_en;

    assign fifo_err = (bus.lb0_wr_en & bus.lb0_full) | (bus.lb0_rd_en & bus.lb0_empty)
                    | (bus.lb1_wr_en & bus.lb1_full) | (bus.lb1_rd_en & bus.lb1_empty);

    // ------------------------------------------------------------------
    // Controller FSM and input column/row counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            in_x       <= '0;
            in_y       <= '0;
            frm_done_q <= 1'b0;
        end else begin
            frm_done_q <= 1'b0;
            if (bus.sof_i) begin
                // restart from any state; a partial frame is dropped
                in_x  <= '0;
                in_y  <= '0;
                state <= go_row0 ? S_ROW0 : S_FLUSH;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_FLUSH: begin
                        if (bus.lb0_empty & bus.lb1_empty) begin
                            state <= S_ROW0;
                        end
                    end
                    S_ROW0, S_ROW1, S_ROWN: begin
                        if (acc) begin
                            if (col_last) begin
                                in_x <= '0;
                                in_y <= in_y + CNT_ONE;
                                if (state == S_ROW0) begin
                                    state <= S_ROW1;
                                end else if (state == S_ROW1) begin
                                    state <= S_ROWN;
                                end else if (in_y == Y_LAST) begin
                                    state      <= S_DONE;
                                    frm_done_q <= 1'b1;
                                end
                            end else begin
                                in_x <= in_x + CNT_ONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Window datapath
    // ------------------------------------------------------------------
    assign col_cur = {bus.lb1_rd_data, bus.lb0_rd_data, d_pix};
    assign win_and = &{t2, t1, col_cur};
    // only positions whose full 3x3 neighbourhood lies inside the frame
    assign win_out = d_vld & (d_x >= CNT_TWO) & (d_y >= CNT_TWO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vld     <= 1'b0;
            d_pix     <= 1'b0;
            d_lb0     <= 1'b0;
            d_x       <= '0;
            d_y       <= '0;
            t1        <= '0;
            t2        <= '0;
            ero_vld_q <= 1'b0;
            ero_pix_q <= 1'b0;
            ero_eol_q <= 1'b0;
            ero_eof_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // a pixel accepted together with sof_i belongs to the discarded
            // frame, so it never reaches the aligned stage
            d_vld <= acc & ~bus.sof_i;
            d_pix <= bus.pix_i;
            d_lb0 <= (state == S_ROW1) || (state == S_ROWN);
            d_x   <= in_x;
            d_y   <= in_y;

            // taps only move with real pixels; gaps freeze the window
            if (d_vld) begin
                t2 <= t1;
                t1 <= col_cur;
            end

            ero_vld_q <= win_out;
            ero_pix_q <= win_out & win_and;
            ero_eol_q <= win_out & (d_x == X_LAST);
            ero_eof_q <= win_out & (d_x == X_LAST) & (d_y == Y_LAST);

            err_q <= err_q | fifo_err;
        end
    end

    assign bus.ero_vld_o  = ero_vld_q;
    assign bus.ero_pix_o  = ero_pix_q;
    assign bus.ero_eol_o  = ero_eol_q;
    assign bus.ero_eof_o  = ero_eof_q;
    assign bus.frm_done_o = frm_done_q;
    assign bus.err_o      = err_q;

    // ------------------------------------------------------------------
    // Optional per-frame foreground statistics
    // ------------------------------------------------------------------
`ifdef ERO_STAT_EN
    logic [2*CNT_W-1:0] stat_acc;
    logic [2*CNT_W-1:0] stat_q;
    logic [2*CNT_W-1:0] stat_inc;

    // counted at the aligned stage (one clock ahead of ero_vld_o) so the
    // last output of the frame is already included when DONE is reached
    assign stat_inc = {{(2*CNT_W-1){1'b0}}, (win_out & win_and)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_acc <= '0;
            stat_q   <= '0;
        end else begin
            if (state == S_DONE) begin
                stat_q <= stat_acc + stat_inc;
            end
            if (bus.sof_i || (state == S_DONE)) begin
                stat_acc <= '0;
            end else begin
                stat_acc <= stat_acc + stat_inc;
            end
        end
    end

    assign bus.stat_cnt_o = stat_q;
`else
    assign bus.stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bin_erosion_linebuf_ctrl.sv
module tb_bin_erosion_linebuf_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int CNT_W = 11;
  localparam int DEPTH = 1024;
  localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bin_erosion_linebuf_ctrl_if #(.CNT_W(CNT_W)) bus ();

  bin_erosion_linebuf_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- line buffer FIFO models (read latency 1) ----------------
  bit lb0_q[$];
  bit lb1_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lb0_q.delete();
      bus.lb0_rd_data <= 1'b0;
      bus.lb0_empty   <= 1'b1;
      bus.lb0_full    <= 1'b0;
    end else begin
      if (bus.lb0_rd_en && lb0_q.size() > 0) bus.lb0_rd_data <= lb0_q.pop_front();
      if (bus.lb0_wr_en && lb0_q.size() < DEPTH) lb0_q.push_back(bus.lb0_wr_data);
      bus.lb0_empty <= (lb0_q.size() == 0);
      bus.lb0_full  <= (lb0_q.size() == DEPTH);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lb1_q.delete();
      bus.lb1_rd_data <= 1'b0;
      bus.lb1_empty   <= 1'b1;
      bus.lb1_full    <= 1'b0;
    end else begin
      if (bus.lb1_rd_en && lb1_q.size() > 0) bus.lb1_rd_data <= lb1_q.pop_front();
      if (bus.lb1_wr_en && lb1_q.size() < DEPTH) lb1_q.push_back(bus.lb1_wr_data);
      bus.lb1_empty <= (lb1_q.size() == 0);
      bus.lb1_full  <= (lb1_q.size() == DEPTH);
    end
  end

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];  // {pix, eol, eof}
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  int out_cnt = 0;
  int done_cnt = 0;
  int first_out_cyc = 0;
  bit first_out_seen = 0;
  int acc_22_cyc = 0;
  int exp_ones = 0;
  logic [2:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frm_done_o) done_cnt++;
      if (bus.ero_vld_o) begin
        out_cnt++;
        if (!first_out_seen) begin
          first_out_seen = 1;
          first_out_cyc  = cyc;
        end
        check("out_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("ero_pix_eol_eof", {29'd0, bus.ero_pix_o, bus.ero_eol_o, bus.ero_eof_o}, {29'd0, mon_e});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit img[IMG_H][IMG_W];

  task automatic fill_image(input int mode);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        case (mode)
          0: img[y][x] = 1'b1;
          1: img[y][x] = !(x == 3 && y == 2);
          default: img[y][x] = ($urandom_range(0, 99) < 80);
        endcase
  endtask

  task automatic build_expected();
    bit a;
    exp_ones = 0;
    for (int cy = 1; cy <= IMG_H - 2; cy++)
      for (int cx = 1; cx <= IMG_W - 2; cx++) begin
        a = 1'b1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            a = a & img[cy + dy][cx + dx];
        exp_q.push_back({a, cx == IMG_W - 2, (cx == IMG_W - 2) && (cy == IMG_H - 2)});
        if (a) exp_ones++;
      end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_pixel(input bit p, input int gap_pct, input int idx);
    int guard;
    bit done;
    bit acc_now;
    guard = 0;
    done  = 0;
    while (!done) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        bus.pix_vld_i = 1'b0;
        bus.pix_i     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end else begin
        bus.pix_vld_i = 1'b1;
        bus.pix_i     = p;
        @(negedge clk);
        acc_now = bus.pix_rdy_o;
        if (acc_now && idx == 2 * IMG_W + 2) acc_22_cyc = cyc;
        @(posedge clk); #1;
        bus.pix_vld_i = 1'b0;
        if (acc_now) done = 1;
      end
      guard++;
      if (!done && guard > 2000) begin
        check("pix_accept_timeout", guard, 0);
        done = 1;
      end
    end
  endtask

  task automatic run_frame(input int mode, input int gap_pct, input int npix, input bit expect_flush);
    int g;
    bit complete;
    complete = (npix == IMG_W * IMG_H);
    fill_image(mode);
    out_cnt = 0;
    done_cnt = 0;
    first_out_seen = 0;
    if (complete) build_expected();

    bus.sof_i = 1'b1;
    @(posedge clk); #1;
    bus.sof_i = 1'b0;
    @(negedge clk);
    check("rdy_after_sof", 32'(bus.pix_rdy_o), expect_flush ? 0 : 1);
    g = 0;
    while (!bus.pix_rdy_o && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check("rdy_rises", 32'(bus.pix_rdy_o), 1);
    check("fifos_flushed", lb0_q.size() + lb1_q.size(), 0);
    @(posedge clk); #1;

    for (int idx = 0; idx < npix; idx++)
      drive_pixel(img[idx / IMG_W][idx % IMG_W], gap_pct, idx);

    repeat (6) @(negedge clk);
    if (complete) begin
      check("out_count", out_cnt, N_OUT);
      check("exp_q_drained", exp_q.size(), 0);
      check("frm_done_cycles", done_cnt, 1);
      check("latency_22", first_out_cyc - acc_22_cyc, 2);
`ifdef ERO_STAT_EN
      check("stat_cnt", 32'(bus.stat_cnt_o), exp_ones);
`else
      check("stat_cnt", 32'(bus.stat_cnt_o), 0);
`endif
    end else begin
      check("partial_out_count", out_cnt, 0);
      check("partial_frm_done", done_cnt, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.sof_i     = 1'b0;
    bus.pix_vld_i = 1'b0;
    bus.pix_i     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_rdy",   32'(bus.pix_rdy_o), 0);
    check("rst_ero_vld",   32'(bus.ero_vld_o), 0);
    check("rst_frm_done",  32'(bus.frm_done_o), 0);
    check("rst_err",       32'(bus.err_o), 0);
    check("rst_stat",      32'(bus.stat_cnt_o), 0);
    check("rst_lb_ctrl",   {28'd0, bus.lb0_wr_en, bus.lb0_rd_en, bus.lb1_wr_en, bus.lb1_rd_en}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_pix_rdy",  32'(bus.pix_rdy_o), 0);

    run_frame(0, 0,  IMG_W * IMG_H, 0);  // all ones, FIFOs empty
    run_frame(1, 0,  IMG_W * IMG_H, 1);  // zero at (3,2)
    run_frame(0, 50, IMG_W * IMG_H, 1);  // all ones with gaps
    run_frame(2, 50, IMG_W * IMG_H, 1);  // random with gaps
    run_frame(2, 0,  10,            1);  // aborted after 10 pixels
    run_frame(2, 50, IMG_W * IMG_H, 1);  // frame after abort
    for (int i = 0; i < 4; i++)
      run_frame(2, $urandom_range(0, 60), IMG_W * IMG_H, 1);

    check("err_sticky", 32'(bus.err_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
